// File: rtl/dircc_counter_send_if.sv
// ---------------------------------------------------------------------------
// dircc_counter_send_if
//   Bus bundle between the counter send handler and its two consumers: the
//   node packet output mux (pkt_*) and the device state memory write port
//   (wr_*).
//
//   Handshake rules for both channels:
//     - The producer raises valid (pkt_valid / wr_en) and keeps it high with
//       stable data until the consumer's ready (pkt_ready / wr_ack) is high
//       at a rising clk edge.
//     - That edge is the single transfer point.
//     - The producer never retracts valid before the transfer.
//     - The consumer may hold ready high at any time.
//
//   Signals:
//     pkt_valid   master->slave  packet valid
//     pkt_ready   slave->master  packet accepted
//     pkt_src     master->slave  source device address
//     pkt_payload master->slave  {rts, count} snapshot
//     wr_en       master->slave  state writeback request
//     wr_ack      slave->master  write accepted
//     wr_rts      master->slave  new rts field
//     wr_count    master->slave  new count field
// ---------------------------------------------------------------------------
interface dircc_counter_send_if #(
  parameter int ADDRESS_MEM_WIDTH = 32
);
  logic                         pkt_valid;
  logic                         pkt_ready;
  logic [ADDRESS_MEM_WIDTH-1:0] pkt_src;
  logic [31:0]                  pkt_payload;
  logic                         wr_en;
  logic                         wr_ack;
  logic [15:0]                  wr_rts;
  logic [15:0]                  wr_count;

  modport master (
    output pkt_valid, pkt_src, pkt_payload, wr_en, wr_rts, wr_count,
    input  pkt_ready, wr_ack
  );

  modport slave (
    input  pkt_valid, pkt_src, pkt_payload, wr_en, wr_rts, wr_count,
    output pkt_ready, wr_ack
  );
endinterface

// File: rtl/dircc_counter_send_handler.sv
// ---------------------------------------------------------------------------
// dircc_counter_send_handler
//   Serves the counter device's output port.
//
//   When the registered ready-to-send vector flags the port (PORT_MASK), the
//   block:
//     1. snapshots the device's rts/count state;
//     2. emits one packet {rts, count} from the device address;
//     3. writes back (rts-1, count+1) to state memory;
//     4. idles COOLDOWN_CYCLES cycles so the registered ready vector can
//        catch up with the write before it is sampled again.
//
//   Ports:
//     clk, reset_n    clock, synchronous active-low reset
//     rts_ready       registered ready-to-send vector
//     device_address  address of the presented device
//     cur_rts         rts field of the current device state
//     cur_count       count field of the current device state
//     bus             packet + writeback channels (master side)
//     busy            registered, high whenever the FSM is not IDLE
//     sent_total      accepted packet count (wraps)
//     state_dbg_o     current FSM state, for observation only
// ---------------------------------------------------------------------------
module dircc_counter_send_handler #(
  parameter int          ADDRESS_MEM_WIDTH = 32,
  parameter logic [31:0] PORT_MASK         = 32'h0000_0001,
  // Legal range 1..15 (the counter is 4 bits wide).
  parameter int          COOLDOWN_CYCLES   = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [31:0]                  rts_ready,
  input  logic [ADDRESS_MEM_WIDTH-1:0] device_address,
  input  logic [15:0]                  cur_rts,
  input  logic [15:0]                  cur_count,
  dircc_counter_send_if.master         bus,
  output logic                         busy,
  output logic [31:0]                  sent_total,
  output logic [1:0]                   state_dbg_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WRITEBACK = 2'd2,
    S_COOLDOWN  = 2'd3
  } state_t;

  // Counter counts down to zero, so load one less than the cycle count to
  // stay in COOLDOWN exactly COOLDOWN_CYCLES cycles.
  localparam logic [3:0] COOL_LOAD = 4'(COOLDOWN_CYCLES - 1);

  state_t                       state_q, state_d;
  logic [3:0]                   cool_q, cool_d;
  logic                         pkt_valid_q, pkt_valid_d;
  logic [ADDRESS_MEM_WIDTH-1:0] pkt_src_q, pkt_src_d;
  logic [31:0]                  pkt_payload_q, pkt_payload_d;
  logic                         wr_en_q, wr_en_d;
  logic [15:0]                  wr_rts_q, wr_rts_d;
  logic [15:0]                  wr_count_q, wr_count_d;
  logic                         busy_q;
  logic [31:0]                  sent_total_q, sent_total_d;

  logic take;
  logic pkt_fire;
  logic wr_fire;

  // A flag with rts==0 is stale: the ready vector has not yet seen the last
  // writeback, so it must not trigger a packet.
  assign take     = ((rts_ready & PORT_MASK) != 32'd0) && (cur_rts != 16'd0);
  assign pkt_fire = pkt_valid_q && bus.pkt_ready;
  assign wr_fire  = wr_en_q && bus.wr_ack;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cool_q        <= 4'd0;
      pkt_valid_q   <= 1'b0;
      pkt_src_q     <= '0;
      pkt_payload_q <= 32'd0;
      wr_en_q       <= 1'b0;
      wr_rts_q      <= 16'd0;
      wr_count_q    <= 16'd0;
      busy_q        <= 1'b0;
      sent_total_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      cool_q        <= cool_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_src_q     <= pkt_src_d;
      pkt_payload_q <= pkt_payload_d;
      wr_en_q       <= wr_en_d;
      wr_rts_q      <= wr_rts_d;
      wr_count_q    <= wr_count_d;
      busy_q        <= (state_d != S_IDLE);
      sent_total_q  <= sent_total_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (take)          state_d = S_SEND;
      S_SEND:      if (pkt_fire)      state_d = S_WRITEBACK;
      S_WRITEBACK: if (wr_fire)       state_d = S_COOLDOWN;
      S_COOLDOWN:  if (cool_q == 4'd0) state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    cool_d        = cool_q;
    pkt_valid_d   = pkt_valid_q;
    pkt_src_d     = pkt_src_q;
    pkt_payload_d = pkt_payload_q;
    wr_en_d       = wr_en_q;
    wr_rts_d      = wr_rts_q;
    wr_count_d    = wr_count_q;
    sent_total_d  = sent_total_q;
    case (state_q)
      S_IDLE: begin
        // The packet registers double as the snapshot used for writeback.
        if (take) begin
          pkt_valid_d   = 1'b1;
          pkt_src_d     = device_address;
          pkt_payload_d = {cur_rts, cur_count};
        end
      end
      S_SEND: begin
        if (pkt_fire) begin
          pkt_valid_d  = 1'b0;
          sent_total_d = sent_total_q + 32'd1;
          wr_en_d      = 1'b1;
          wr_rts_d     = pkt_payload_q[31:16] - 16'd1;
          wr_count_d   = pkt_payload_q[15:0] + 16'd1;
        end
      end
      S_WRITEBACK: begin
        if (wr_fire) begin
          wr_en_d = 1'b0;
          cool_d  = COOL_LOAD;
        end
      end
      S_COOLDOWN: begin
        if (cool_q != 4'd0) cool_d = cool_q - 4'd1;
      end
      default: ;
    endcase
  end

  assign bus.pkt_valid   = pkt_valid_q;
  assign bus.pkt_src     = pkt_src_q;
  assign bus.pkt_payload = pkt_payload_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_rts      = wr_rts_q;
  assign bus.wr_count    = wr_count_q;
  assign busy            = busy_q;
  assign sent_total      = sent_total_q;
  assign state_dbg_o     = state_q;

endmodule

// File: doc/dircc_counter_send_handler.md
Name: dircc_counter_send_handler

Overview:
- Downstream consumer of the counter device's registered ready-to-send vector.
- When the device's output port is flagged ready, snapshots the device's rts/count fields and emits one packet on a valid/ready output interface.
- Writes the updated state back to device memory (rts-1, count+1), then waits for the registered ready vector to reflect the write before it rearms.
- Sits between the rts handler and the node's packet output mux / state memory write port.

Parameters:
- ADDRESS_MEM_WIDTH, 32, width of device address and packet source field.
- PORT_MASK, 32'h0000_0001, rts_ready bit(s) served by this block (dev_port0).
- COOLDOWN_CYCLES, 2, idle cycles after writeback before rts_ready is sampled again; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- rts_ready  in  32  registered ready-to-send vector from the rts handler.
- device_address  in  ADDRESS_MEM_WIDTH  address of the device whose state is presented.
- cur_rts  in  16  rts field of the current device state (user_state[31:16]).
- cur_count  in  16  count field of the current device state (user_state[15:0]).
- pkt_valid  out  1  output packet valid.
- pkt_ready  in  1  downstream accepts the packet.
- pkt_src  out  ADDRESS_MEM_WIDTH  source address of the packet.
- pkt_payload  out  32  {rts snapshot, count snapshot}.
- wr_en  out  1  state writeback request.
- wr_ack  in  1  state memory accepted the write.
- wr_rts  out  16  new rts value.
- wr_count  out  16  new count value.
- busy  out  1  high in any state other than IDLE.
- sent_total  out  32  number of accepted packets; wraps at 2^32.

Behaviour:
- Reset, synchronous (reset_n sampled low at a clk edge):
  - FSM goes to IDLE.
  - pkt_valid, wr_en, busy = 0.
  - pkt_src, pkt_payload, wr_rts, wr_count = 0.
  - sent_total = 0.
  - Cooldown counter = 0.
  - Reset mid-operation abandons any pending packet or write with no completion; outputs are at their reset values on the cycle after the sampling edge.
- FSM states: IDLE, SEND, WRITEBACK, COOLDOWN.
- IDLE:
  - If (rts_ready & PORT_MASK) != 0, latch snapshots snap_rts = cur_rts, snap_count = cur_count, snap_addr = device_address.
  - If snap value cur_rts == 0 (stale flag), stay in IDLE and send nothing.
  - Otherwise go to SEND.
- SEND:
  - pkt_valid = 1; pkt_src = snap_addr; pkt_payload = {snap_rts, snap_count}. These values are registered and stable until the handshake.
  - Handshake completes on the edge where pkt_valid and pkt_ready are both high. pkt_ready may already be high on the first SEND cycle; that is a 1-cycle transfer.
  - On the handshake: pkt_valid drops next cycle, sent_total increments, FSM goes to WRITEBACK.
  - rts_ready deasserting during SEND is ignored: no retraction, and the payload does not change.
- WRITEBACK:
  - wr_en = 1, wr_rts = snap_rts - 1, wr_count = snap_count + 1 (mod 2^16, so 16'hFFFF wraps to 0).
  - Held until wr_ack is sampled high; then wr_en drops next cycle and the FSM goes to COOLDOWN.
- COOLDOWN:
  - Stays exactly COOLDOWN_CYCLES cycles, with rts_ready ignored.
  - Then goes to IDLE.
- busy = (state != IDLE), registered.
- Latency: rts_ready high at edge N gives pkt_valid high after edge N+1, i.e. one registered cycle.
- Minimum packet spacing with pkt_ready and wr_ack tied high: 1 (IDLE) + 1 (SEND) + 1 (WRITEBACK) + COOLDOWN_CYCLES cycles = 5 cycles at the default.
- rts_ready bits outside PORT_MASK are never acted on.

Test Plan:
- Reset, then cur_rts=3, cur_count=0, rts_ready=1 held, pkt_ready=1, wr_ack=1, with the bench model updating cur_* on write:
  - Exactly 3 packets, payloads 0x0003_0000, 0x0002_0001, 0x0001_0002.
  - Writes (2,1), (1,2), (0,3).
  - sent_total=3; no fourth packet once rts_ready falls.
- pkt_ready low for 4 cycles after pkt_valid rises:
  - pkt_valid and payload stable for all 4 cycles.
  - A single transfer on the cycle pkt_ready rises; sent_total +1 only.
- rts_ready=1 with cur_rts=0 (stale) -> no pkt_valid, busy stays 0.
- cur_rts=1, cur_count=16'hFFFF -> wr_count=0, wr_rts=0.
- rts_ready=32'h0000_0002 with default PORT_MASK -> no activity for 20 cycles.
- reset_n driven low mid-SEND, then mid-WRITEBACK:
  - pkt_valid, wr_en, busy = 0 on the next cycle, sent_total=0.
  - After release with rts_ready=1, the next packet carries fresh cur_* values.
